// File: rtl/safe_lock_if.sv
// Command pulses in, entry/status out, between the button-pulse logic and safe_lock_ctrl.
interface safe_lock_if #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned DIGIT_W  = 4,
   parameter int unsigned MAX_FAIL = 3
);
   localparam int unsigned ENTRY_W = DIGITS * DIGIT_W;
   localparam int unsigned CUR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned FC_W    = $clog2(MAX_FAIL + 1);

   logic               up;
   logic               down;
   logic               slide;
   logic               set_req;
   logic               set_commit;
   logic               check_req;
   logic [ENTRY_W-1:0] entry;
   logic [CUR_W-1:0]   cursor;
   logic [1:0]         result;
   logic [FC_W-1:0]    fail_cnt;
   logic               authorized;
   logic               busy;

   modport master (
      output up, down, slide, set_req, set_commit, check_req,
      input  entry, cursor, result, fail_cnt, authorized, busy
   );

   modport slave (
      input  up, down, slide, set_req, set_commit, check_req,
      output entry, cursor, result, fail_cnt, authorized, busy
   );
endinterface

// File: rtl/safe_lock_ctrl.sv
// Password entry/verification controller with authorised change and timed result.
// Optional lockout after MAX_FAIL consecutive failures: define SAFE_LOCK_LOCKOUT_EN.
module safe_lock_ctrl #(
   parameter int unsigned DIGITS        = 4,
   parameter int unsigned DIGIT_W       = 4,
   parameter int unsigned MAX_DIGIT     = 9,
   parameter int unsigned MAX_FAIL      = 3,
   parameter int unsigned RESULT_CYCLES = 200,
   parameter int unsigned LOCK_CYCLES   = 3000
) (
   input logic        clk,
   input logic        reset_n,
   safe_lock_if.slave bus
);
   localparam int unsigned ENTRY_W = DIGITS * DIGIT_W;
   localparam int unsigned CUR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned FC_W    = $clog2(MAX_FAIL + 1);
   localparam int unsigned TMR_MAX = (LOCK_CYCLES > RESULT_CYCLES) ? LOCK_CYCLES : RESULT_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [1:0] RES_IDLE = 2'b00;
   localparam logic [1:0] RES_PASS = 2'b01;
   localparam logic [1:0] RES_FAIL = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_SET, S_CHECK, S_RESULT, S_LOCKED} state_e;

   state_e             state_q, state_d;
   logic [ENTRY_W-1:0] entry_q, entry_d;
   logic [ENTRY_W-1:0] stored_q, stored_d;
   logic [CUR_W-1:0]   cursor_q, cursor_d;
   logic [1:0]         result_q, result_d;
   logic [FC_W-1:0]    fail_q, fail_d;
   logic               auth_q, auth_d;
   logic               busy_q, busy_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;

   logic               match;
   logic [FC_W-1:0]    fail_inc;
   logic [DIGIT_W-1:0] dig;

   assign match    = (entry_q == stored_q);
   assign fail_inc = (fail_q == FC_W'(MAX_FAIL)) ? fail_q : fail_q + FC_W'(1);

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         entry_q  <= '0;
         stored_q <= '0;
         cursor_q <= '0;
         result_q <= RES_IDLE;
         fail_q   <= '0;
         auth_q   <= 1'b0;
         busy_q   <= 1'b0;
         tmr_q    <= '0;
      end else begin
         state_q  <= state_d;
         entry_q  <= entry_d;
         stored_q <= stored_d;
         cursor_q <= cursor_d;
         result_q <= result_d;
         fail_q   <= fail_d;
         auth_q   <= auth_d;
         busy_q   <= busy_d;
         tmr_q    <= tmr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.set_req && auth_q) state_d = S_SET;
            else if (bus.check_req)    state_d = S_CHECK;
         end
         S_SET: begin
            if (bus.set_commit || !bus.set_req) state_d = S_IDLE;
         end
         S_CHECK: begin
            state_d = S_RESULT;
`ifdef SAFE_LOCK_LOCKOUT_EN
            if (!match && fail_inc == FC_W'(MAX_FAIL)) state_d = S_LOCKED;
`endif
         end
         S_RESULT: begin
            if (tmr_q == '0) state_d = S_IDLE;
         end
`ifdef SAFE_LOCK_LOCKOUT_EN
         S_LOCKED: begin
            if (tmr_q == '0) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      entry_d  = entry_q;
      stored_d = stored_q;
      cursor_d = cursor_q;
      result_d = result_q;
      fail_d   = fail_q;
      auth_d   = auth_q;
      tmr_d    = tmr_q;
      dig      = '0;
      busy_d   = (state_d == S_CHECK) || (state_d == S_RESULT) || (state_d == S_LOCKED);

      // Edits hit the digit under the old cursor even when slide moves it this cycle
      if (state_q == S_IDLE || state_q == S_SET) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cursor_q == CUR_W'(i)) begin
               dig = entry_q[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
               if (bus.up && !bus.down)
                  dig = (dig == DIGIT_W'(MAX_DIGIT)) ? '0 : dig + DIGIT_W'(1);
               else if (bus.down && !bus.up)
                  dig = (dig == '0) ? DIGIT_W'(MAX_DIGIT) : dig - DIGIT_W'(1);
               entry_d[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = dig;
            end
         end
         if (bus.slide)
            cursor_d = (cursor_q == CUR_W'(DIGITS-1)) ? '0 : cursor_q + CUR_W'(1);
      end

      case (state_q)
         S_SET: begin
            if (bus.set_commit) begin
               stored_d = entry_q;
               auth_d   = 1'b0;
            end else if (!bus.set_req) begin
               auth_d   = 1'b0;
            end
         end
         S_CHECK: begin
            tmr_d = TMR_W'(RESULT_CYCLES - 1);
            if (match) begin
               result_d = RES_PASS;
               fail_d   = '0;
               auth_d   = 1'b1;
            end else begin
               result_d = RES_FAIL;
               fail_d   = fail_inc;
               auth_d   = 1'b0;
`ifdef SAFE_LOCK_LOCKOUT_EN
               if (fail_inc == FC_W'(MAX_FAIL)) begin
                  result_d = 2'b11;
                  tmr_d    = TMR_W'(LOCK_CYCLES - 1);
               end
`endif
            end
         end
         S_RESULT: begin
            if (tmr_q == '0) begin
               result_d = RES_IDLE;
               entry_d  = '0;
               cursor_d = '0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
`ifdef SAFE_LOCK_LOCKOUT_EN
         S_LOCKED: begin
            if (tmr_q == '0) begin
               result_d = RES_IDLE;
               fail_d   = '0;
               entry_d  = '0;
               cursor_d = '0;
            end else begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
`endif
         default: ;
      endcase
   end

   assign bus.entry      = entry_q;
   assign bus.cursor     = cursor_q;
   assign bus.result     = result_q;
   assign bus.fail_cnt   = fail_q;
   assign bus.authorized = auth_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_safe_lock_ctrl.sv
// Directed bench for safe_lock_ctrl: edit vector table plus hand-written check/set/lock sequences.
module tb_safe_lock_ctrl;
   logic clk;
   logic reset_n;
   int   total;
   int   bad;
   int   n;
   logic [15:0] snap;

   safe_lock_if #(.DIGITS(4), .DIGIT_W(4), .MAX_FAIL(3)) bus ();

   safe_lock_ctrl #(
      .DIGITS(4), .DIGIT_W(4), .MAX_DIGIT(9), .MAX_FAIL(3),
      .RESULT_CYCLES(200), .LOCK_CYCLES(3000)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        up;
      logic        down;
      logic        slide;
      logic [15:0] entry;
      logic [1:0]  cursor;
   } vec_t;

   vec_t vt[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic u, input logic d, input logic s);
      bus.up = u; bus.down = d; bus.slide = s;
      cyc();
      bus.up = 1'b0; bus.down = 1'b0; bus.slide = 1'b0;
   endtask

   task automatic count_code(input logic [1:0] code, output int cnt);
      cnt = 0;
      while (bus.result == code && cnt < 5000) begin
         cnt++;
         cyc();
      end
   endtask

   task automatic do_check(input string nm, input logic [1:0] exp_res, input logic [1:0] exp_fail,
                           input logic exp_auth);
      bus.check_req = 1'b1;
      cyc();
      bus.check_req = 1'b0;
      chk({nm, "_busy_in_check"}, 32'(bus.busy), 32'd1);
      cyc();
      chk({nm, "_result"}, 32'(bus.result), 32'(exp_res));
      chk({nm, "_fail_cnt"}, 32'(bus.fail_cnt), 32'(exp_fail));
      chk({nm, "_auth"}, 32'(bus.authorized), 32'(exp_auth));
   endtask

   task automatic finish_result(input string nm, input logic [1:0] code);
      int cnt;
      count_code(code, cnt);
      chk({nm, "_hold_len"}, 32'(cnt), 32'd200);
      chk({nm, "_result_idle"}, 32'(bus.result), 32'd0);
      chk({nm, "_entry_clr"}, 32'(bus.entry), 32'd0);
      chk({nm, "_busy_clr"}, 32'(bus.busy), 32'd0);
   endtask

   task automatic enter_3700();
      repeat (3) pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      repeat (7) pulse(1'b1, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_entry"}, 32'(bus.entry), 32'd0);
      chk({nm, "_cursor"}, 32'(bus.cursor), 32'd0);
      chk({nm, "_result"}, 32'(bus.result), 32'd0);
      chk({nm, "_fail"}, 32'(bus.fail_cnt), 32'd0);
      chk({nm, "_auth"}, 32'(bus.authorized), 32'd0);
      chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0; bad = 0;
      bus.up = 1'b0; bus.down = 1'b0; bus.slide = 1'b0;
      bus.set_req = 1'b0; bus.set_commit = 1'b0; bus.check_req = 1'b0;

      // {up, down, slide} -> entry/cursor after the edge; digit 0 is the top nibble
      vt[0]  = '{1'b0, 1'b1, 1'b0, 16'h9000, 2'd0};
      vt[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd0};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 16'h1000, 2'd0};
      vt[3]  = '{1'b1, 1'b1, 1'b0, 16'h1000, 2'd0};
      vt[4]  = '{1'b1, 1'b0, 1'b1, 16'h2000, 2'd1};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 16'h2900, 2'd1};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 16'h2000, 2'd1};
      vt[7]  = '{1'b0, 1'b0, 1'b1, 16'h2000, 2'd2};
      vt[8]  = '{1'b0, 1'b1, 1'b1, 16'h2090, 2'd3};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 16'h2090, 2'd0};
      vt[10] = '{1'b0, 1'b1, 1'b0, 16'h1090, 2'd0};
      vt[11] = '{1'b0, 1'b1, 1'b0, 16'h0090, 2'd0};
      vt[12] = '{1'b0, 1'b0, 1'b1, 16'h0090, 2'd1};
      vt[13] = '{1'b0, 1'b0, 1'b1, 16'h0090, 2'd2};
      vt[14] = '{1'b1, 1'b0, 1'b0, 16'h0000, 2'd2};
      vt[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'd3};
      vt[16] = '{1'b0, 1'b0, 1'b1, 16'h0000, 2'd0};

      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      chk_reset_vals("reset");
      reset_n = 1'b1;
      cyc();

      for (int i = 0; i < 17; i++) begin
         pulse(vt[i].up, vt[i].down, vt[i].slide);
         chk($sformatf("edit%0d_entry", i), 32'(bus.entry), 32'(vt[i].entry));
         chk($sformatf("edit%0d_cursor", i), 32'(bus.cursor), 32'(vt[i].cursor));
      end

      // set request without authorisation must not open set mode
      bus.set_req = 1'b1;
      cyc();
      pulse(1'b1, 1'b0, 1'b0);
      bus.set_commit = 1'b1;
      cyc();
      bus.set_commit = 1'b0;
      bus.set_req = 1'b0;
      chk("unauth_busy", 32'(bus.busy), 32'd0);
      chk("unauth_auth", 32'(bus.authorized), 32'd0);
      pulse(1'b0, 1'b1, 1'b0);

      do_check("pass0", 2'b01, 2'd0, 1'b1);
      chk("pass0_busy", 32'(bus.busy), 32'd1);
      finish_result("pass0", 2'b01);
      chk("pass0_auth_kept", 32'(bus.authorized), 32'd1);

      // authorised change to 3700; commit coincides with set_req falling
      bus.set_req = 1'b1;
      cyc();
      enter_3700();
      bus.set_commit = 1'b1;
      bus.set_req = 1'b0;
      cyc();
      bus.set_commit = 1'b0;
      chk("set_entry", 32'(bus.entry), 32'h3700);
      chk("set_auth_clr", 32'(bus.authorized), 32'd0);
      chk("set_busy", 32'(bus.busy), 32'd0);

      repeat (7) pulse(1'b0, 1'b1, 1'b0);
      repeat (3) pulse(1'b0, 1'b0, 1'b1);
      repeat (3) pulse(1'b0, 1'b1, 1'b0);
      chk("cleared_entry", 32'(bus.entry), 32'h0000);
      do_check("old0", 2'b10, 2'd1, 1'b0);
      finish_result("old0", 2'b10);

      enter_3700();
      do_check("new3700", 2'b01, 2'd0, 1'b1);
      finish_result("new3700", 2'b01);

      // set mode aborted by releasing set_req keeps 3700
      bus.set_req = 1'b1;
      cyc();
      pulse(1'b1, 1'b0, 1'b0);
      bus.set_req = 1'b0;
      cyc();
      chk("abort_auth", 32'(bus.authorized), 32'd0);
      chk("abort_entry", 32'(bus.entry), 32'h1000);
      do_check("abort_chk", 2'b10, 2'd1, 1'b0);
      finish_result("abort_chk", 2'b10);

      do_check("fail2", 2'b10, 2'd2, 1'b0);
      finish_result("fail2", 2'b10);

`ifdef SAFE_LOCK_LOCKOUT_EN
      do_check("fail3", 2'b11, 2'd3, 1'b0);
      chk("lock_busy", 32'(bus.busy), 32'd1);
      snap = bus.entry;
      n = 0;
      while (bus.result == 2'b11 && n < 5000) begin
         n++;
         bus.up = (n < 4);
         bus.check_req = (n == 5);
         bus.slide = (n == 6);
         cyc();
         if (n == 8) begin
            chk("lock_entry_frozen", 32'(bus.entry), 32'(snap));
            chk("lock_cursor_frozen", 32'(bus.cursor), 32'd0);
            chk("lock_busy_held", 32'(bus.busy), 32'd1);
         end
      end
      bus.up = 1'b0; bus.check_req = 1'b0; bus.slide = 1'b0;
      chk("lock_len", 32'(n), 32'd3000);
      chk("unlock_result", 32'(bus.result), 32'd0);
      chk("unlock_fail", 32'(bus.fail_cnt), 32'd0);
      chk("unlock_entry", 32'(bus.entry), 32'd0);
      chk("unlock_busy", 32'(bus.busy), 32'd0);

      do_check("relock1", 2'b10, 2'd1, 1'b0);
      finish_result("relock1", 2'b10);
      do_check("relock2", 2'b10, 2'd2, 1'b0);
      finish_result("relock2", 2'b10);
      do_check("relock3", 2'b11, 2'd3, 1'b0);
`else
      do_check("fail3", 2'b10, 2'd3, 1'b0);
      finish_result("fail3", 2'b10);
      do_check("fail4_sat", 2'b10, 2'd3, 1'b0);
      finish_result("fail4_sat", 2'b10);
      do_check("fail5_sat", 2'b10, 2'd3, 1'b0);
`endif

      // asynchronous reset in the middle of a busy state
      repeat (5) cyc();
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midreset");
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      cyc();
      do_check("post_reset", 2'b01, 2'd0, 1'b1);
      finish_result("post_reset", 2'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
